qkv_phase_sequencer: RTL and testbench
======================================

Name: qkv_phase_sequencer

Overview:
Parametrised phase controller and SRAM port arbiter for the N_CH projection output memories (Q/K/V, extendable to more heads or channels).
- Sequences the phases: host load → projection engines → attention read-out → host dump.
- Muxes each memory's address and write-enable (WEB) among host, projection engine and attention engine.
- Generates the projection enable and the single-cycle attention start.
- Delivers host dump reads with READ_LAT-aligned valid.

Parameters:
N_CH, 3, number of projection channels / output memories
ADDR_W, 7, output memory address width
READ_LAT, 2, SRAM read latency in cycles (1..4)
WDOG_CYC, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous abort, highest priority
host_load_req  in  1  request LOAD phase
host_load_done  in  1  host finished loading
host_we  in  1  host write strobe (active-high)
host_addr  in  ADDR_W  host address, broadcast to all memories
host_dump_req  in  1  level; hold high to stay in DUMP
proj_done  in  N_CH  per-channel finished (pulse or level)
proj_we  in  N_CH  per-channel engine write strobe
proj_addr  in  N_CH*ADDR_W  per-channel engine address
attn_addr  in  N_CH*ADDR_W  attention read addresses
attn_done  in  1  attention complete
proj_en  out  1  projection engines enable
attn_start  out  1  one-cycle start pulse
mem_web  out  N_CH  SRAM WEB (0 = write)
mem_addr  out  N_CH*ADDR_W  SRAM address
rd_valid  out  1  host dump data valid on SRAM Q
rd_addr  out  ADDR_W  address matching the current rd_valid
phase  out  3  current state encoding
err  out  1  sticky protocol error

Behaviour:
- States: IDLE=0, LOAD=1, PROJ=2, ATTN=3, WAIT_DUMP=4, DUMP=5, DRAIN=6.
- Reset values: phase=IDLE; proj_en=0; attn_start=0; mem_web=all 1; mem_addr=0; rd_valid=0; rd_addr=0; err=0; done_mask=0.
- Transitions:
  - IDLE→LOAD on host_load_req.
  - LOAD→PROJ on host_load_done.
  - PROJ→ATTN when done_mask is all ones.
  - ATTN→WAIT_DUMP on attn_done.
  - WAIT_DUMP→DUMP on host_dump_req.
  - DUMP→DRAIN when host_dump_req falls.
  - DRAIN→IDLE after READ_LAT cycles.
- Port mux, combinational from the registered state:
  - IDLE/LOAD: mem_addr=host_addr, mem_web=~host_we on every channel.
  - PROJ: mem_addr/mem_web come from proj_addr/proj_we per channel.
  - ATTN: mem_addr=attn_addr, mem_web forced to 1.
  - WAIT_DUMP/DUMP/DRAIN: mem_addr=host_addr, mem_web forced to 1.
- proj_en is registered: high exactly while phase==PROJ; rises 1 cycle after host_load_done is sampled.
- done_mask:
  - Set per bit on proj_done while in PROJ, including the first PROJ cycle; cleared on entry to LOAD.
  - proj_done outside PROJ is ignored.
  - Channels may finish in any order or simultaneously.
- attn_start: 1 for exactly the first cycle of ATTN; never re-fires until the next PROJ→ATTN transition.
- Dump read pipeline:
  - Each DUMP cycle issues one read of host_addr.
  - rd_valid/rd_addr appear exactly READ_LAT cycles later through a READ_LAT-deep shift register.
  - DRAIN lets in-flight reads emerge; no read is issued in DRAIN.
- err set (sticky until reset) on any of:
  - host_we in any state other than IDLE/LOAD; the write is suppressed.
  - proj_we outside PROJ.
  - attn_done outside ATTN.
- abort:
  - Next cycle: phase=IDLE, proj_en=0, done_mask=0, read pipeline flushed (rd_valid=0).
  - err is unchanged.
  - abort takes priority over all other inputs in the same cycle.
- Asynchronous reset mid-operation returns every output to its reset value immediately; mem_web=1 guarantees no spurious write.

Optional Feature:
Macro QKV_SEQ_WDOG_EN.
- Defined: a 16-bit counter clears on entry to PROJ or ATTN and counts while in either state. Reaching WDOG_CYC sets err and forces IDLE next cycle, same actions as abort.
- Undefined: no counter; PROJ and ATTN wait indefinitely.

Decomposition:
- Shared package qkv_pkg holds:
  - the phase_e enum (3-bit, encodings above);
  - the constants QKV_N_CH_DEF=3 and QKV_ADDR_W_DEF=7.
- Natural sub-module: qkv_rd_align, a parametrised READ_LAT-deep valid/address shift register with synchronous flush.

Test Plan:
- Full flow, N_CH=3, READ_LAT=2:
  - Stimulus: load 4 words, proj_done pulses at cycles 10/14/12, attn_done, dump addrs 0..3.
  - Required: one attn_start on the cycle after the proj_done at cycle 14; rd_valid high 2 cycles after each dump addr with rd_addr=0,1,2,3.
- Simultaneous done: all three proj_done in the first PROJ cycle → ATTN on the next cycle; proj_en high for exactly 1 cycle.
- Protocol error: host_we=1 during PROJ → mem_web stays the engine's value, err=1 and stays 1 after abort.
- Abort during DUMP with 2 reads in flight → rd_valid=0 on the next cycle, phase=IDLE, no further rd_valid.
- Reset mid-PROJ: assert rst_n=0 asynchronously → proj_en=0 and mem_web=3'b111 before the next clk edge.
- With QKV_SEQ_WDOG_EN and WDOG_CYC=64: stall in ATTN → err=1 and phase=IDLE at cycle 64 after ATTN entry; without the macro, still in ATTN at cycle 200.

Source files
------------

// File: rtl/qkv_pkg.sv
// Shared types and defaults for the Q/K/V phase sequencer slice.
//   phase_e        : 3-bit phase encoding (also driven on the phase output)
//   QKV_*_DEF      : default channel count and output-memory address width
//   is_host_phase  : true while the host owns the memory write port
package qkv_pkg;

    localparam int unsigned QKV_N_CH_DEF   = 3;
    localparam int unsigned QKV_ADDR_W_DEF = 7;
    localparam int unsigned QKV_PHASE_W    = 3;

    typedef enum logic [QKV_PHASE_W-1:0] {
        PH_IDLE      = 3'd0,
        PH_LOAD      = 3'd1,
        PH_PROJ      = 3'd2,
        PH_ATTN      = 3'd3,
        PH_WAIT_DUMP = 3'd4,
        PH_DUMP      = 3'd5,
        PH_DRAIN     = 3'd6
    } phase_e;

    function automatic logic is_host_phase(input phase_e ph);
        return (ph == PH_IDLE) || (ph == PH_LOAD);
    endfunction

endpackage

// File: rtl/qkv_phase_sequencer_if.sv
// Host / engine / SRAM-port bundle of the phase sequencer.
//   master : host, projection engines and attention engine side (drives requests)
//   slave  : the sequencer (drives enables, SRAM port and dump read-out)
interface qkv_phase_sequencer_if #(
    parameter int unsigned N_CH   = qkv_pkg::QKV_N_CH_DEF,
    parameter int unsigned ADDR_W = qkv_pkg::QKV_ADDR_W_DEF
);
    import qkv_pkg::*;

    logic                     abort;
    logic                     host_load_req;
    logic                     host_load_done;
    logic                     host_we;
    logic [ADDR_W-1:0]        host_addr;
    logic                     host_dump_req;
    logic [N_CH-1:0]          proj_done;
    logic [N_CH-1:0]          proj_we;
    logic [N_CH*ADDR_W-1:0]   proj_addr;
    logic [N_CH*ADDR_W-1:0]   attn_addr;
    logic                     attn_done;
    logic                     proj_en;
    logic                     attn_start;
    logic [N_CH-1:0]          mem_web;
    logic [N_CH*ADDR_W-1:0]   mem_addr;
    logic                     rd_valid;
    logic [ADDR_W-1:0]        rd_addr;
    logic [QKV_PHASE_W-1:0]   phase;
    logic                     err;

    modport master (
        output abort, host_load_req, host_load_done, host_we, host_addr, host_dump_req,
               proj_done, proj_we, proj_addr, attn_addr, attn_done,
        input  proj_en, attn_start, mem_web, mem_addr, rd_valid, rd_addr, phase, err
    );

    modport slave (
        input  abort, host_load_req, host_load_done, host_we, host_addr, host_dump_req,
               proj_done, proj_we, proj_addr, attn_addr, attn_done,
        output proj_en, attn_start, mem_web, mem_addr, rd_valid, rd_addr, phase, err
    );

endinterface

// File: rtl/qkv_rd_align.sv
// READ_LAT-deep valid/address shift register aligning host dump reads with SRAM Q.
//   clk, rst_n : clock, async active-low reset
//   flush_i    : synchronous flush of every in-flight read
//   issue_i    : a read of addr_i is issued this cycle
//   rd_valid_o : read issued DEPTH cycles ago is on SRAM Q now
//   rd_addr_o  : address of that read
module qkv_rd_align #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              rd_valid_o,
    output logic [ADDR_W-1:0] rd_addr_o
);

    logic [DEPTH-1:0]  vld_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    // Empty slots carry address 0 so rd_addr idles at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) addr_q[i] <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) addr_q[i] <= '0;
        end else begin
            vld_q[0]  <= issue_i;
            addr_q[0] <= issue_i ? addr_i : '0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign rd_valid_o = vld_q[DEPTH-1];
    assign rd_addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/qkv_phase_sequencer.sv
// Phase controller and SRAM port arbiter for the N_CH projection output memories.
// Sequences host load -> projection -> attention -> host dump, muxes each memory's
// address/WEB among host, projection engine and attention engine, and aligns dump reads.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of qkv_phase_sequencer_if (all control, SRAM port, dump outputs)
// Optional watchdog: define QKV_SEQ_WDOG_EN to abort PROJ/ATTN after WDOG_CYC cycles.
module qkv_phase_sequencer
    import qkv_pkg::*;
#(
    parameter int unsigned N_CH     = QKV_N_CH_DEF,
    parameter int unsigned ADDR_W   = QKV_ADDR_W_DEF,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned WDOG_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qkv_phase_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = 3;

    phase_e            state_q, state_d;
    logic [N_CH-1:0]   done_mask_q, done_mask_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              proj_en_q, proj_en_d;
    logic              attn_start_q, attn_start_d;
    logic              err_q, err_d;
    logic              flush_c;
    logic              issue_c;
    logic              proto_err_c;
    logic              wdog_hit_c;
    logic [N_CH-1:0]         mem_web_c;
    logic [N_CH*ADDR_W-1:0]  mem_addr_c;

`ifdef QKV_SEQ_WDOG_EN
    logic [15:0] wdog_q, wdog_d;

    // Counts consecutive cycles spent in one PROJ or ATTN visit.
    always_comb begin
        wdog_d = '0;
        if ((state_d == state_q) && ((state_q == PH_PROJ) || (state_q == PH_ATTN)))
            wdog_d = wdog_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end

    assign wdog_hit_c = ((state_q == PH_PROJ) || (state_q == PH_ATTN)) &&
                        (wdog_q == 16'(WDOG_CYC - 1));
`else
    // Watchdog absent: PROJ/ATTN wait indefinitely.
    assign wdog_hit_c = 1'b0 & (WDOG_CYC == 0);
`endif

    assign proto_err_c = (bus.host_we && !is_host_phase(state_q)) ||
                         ((|bus.proj_we) && (state_q != PH_PROJ)) ||
                         (bus.attn_done && (state_q != PH_ATTN));

    // Next-state and registered-output logic; abort/watchdog override everything.
    always_comb begin
        state_d     = state_q;
        done_mask_d = done_mask_q;
        drain_d     = '0;
        err_d       = err_q | proto_err_c;
        flush_c     = 1'b0;

        case (state_q)
            PH_IDLE: begin
                if (bus.host_load_req) begin
                    state_d     = PH_LOAD;
                    done_mask_d = '0;
                end
            end
            PH_LOAD: begin
                if (bus.host_load_done) state_d = PH_PROJ;
            end
            PH_PROJ: begin
                // Bits set this cycle count immediately, so all-done advances next cycle.
                done_mask_d = done_mask_q | bus.proj_done;
                if (&done_mask_d) state_d = PH_ATTN;
            end
            PH_ATTN: begin
                if (bus.attn_done) state_d = PH_WAIT_DUMP;
            end
            PH_WAIT_DUMP: begin
                if (bus.host_dump_req) state_d = PH_DUMP;
            end
            PH_DUMP: begin
                if (!bus.host_dump_req) state_d = PH_DRAIN;
            end
            PH_DRAIN: begin
                if (drain_q == CNT_W'(READ_LAT - 1)) state_d = PH_IDLE;
                else                                 drain_d = drain_q + CNT_W'(1);
            end
            default: state_d = PH_IDLE;
        endcase

        if (bus.abort || wdog_hit_c) begin
            state_d     = PH_IDLE;
            done_mask_d = '0;
            drain_d     = '0;
            flush_c     = 1'b1;
            err_d       = err_q | wdog_hit_c;
        end
    end

    assign proj_en_d    = (state_d == PH_PROJ);
    assign attn_start_d = (state_d == PH_ATTN) && (state_q != PH_ATTN);

    // A read is issued only while the host still holds the dump request.
    assign issue_c = (state_q == PH_DUMP) && bus.host_dump_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PH_IDLE;
            done_mask_q  <= '0;
            drain_q      <= '0;
            proj_en_q    <= 1'b0;
            attn_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_mask_q  <= done_mask_d;
            drain_q      <= drain_d;
            proj_en_q    <= proj_en_d;
            attn_start_q <= attn_start_d;
            err_q        <= err_d;
        end
    end

    // SRAM port mux; reset forces WEB high so no write can slip through.
    always_comb begin
        mem_web_c  = '1;
        mem_addr_c = '0;
        if (rst_n) begin
            case (state_q)
                PH_IDLE, PH_LOAD: begin
                    for (int ch = 0; ch < int'(N_CH); ch++) begin
                        mem_addr_c[ch*ADDR_W +: ADDR_W] = bus.host_addr;
                        mem_web_c[ch]                   = ~bus.host_we;
                    end
                end
                PH_PROJ: begin
                    mem_addr_c = bus.proj_addr;
                    mem_web_c  = ~bus.proj_we;
                end
                PH_ATTN: begin
                    mem_addr_c = bus.attn_addr;
                end
                default: begin
                    for (int ch = 0; ch < int'(N_CH); ch++)
                        mem_addr_c[ch*ADDR_W +: ADDR_W] = bus.host_addr;
                end
            endcase
        end
    end

    qkv_rd_align #(
        .DEPTH  (READ_LAT),
        .ADDR_W (ADDR_W)
    ) u_rd_align (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_c),
        .issue_i    (issue_c),
        .addr_i     (bus.host_addr),
        .rd_valid_o (bus.rd_valid),
        .rd_addr_o  (bus.rd_addr)
    );

    assign bus.proj_en    = proj_en_q;
    assign bus.attn_start = attn_start_q;
    assign bus.mem_web    = mem_web_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.phase      = state_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_qkv_phase_sequencer.sv
// Directed self-checking bench for qkv_phase_sequencer (N_CH=3, ADDR_W=7, READ_LAT=2, WDOG_CYC=64).
module tb_qkv_phase_sequencer;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    qkv_phase_sequencer_if #(.N_CH(3), .ADDR_W(7)) bus ();

    qkv_phase_sequencer #(
        .N_CH     (3),
        .ADDR_W   (7),
        .READ_LAT (2),
        .WDOG_CYC (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.abort          = 1'b0;
        bus.host_load_req  = 1'b0;
        bus.host_load_done = 1'b0;
        bus.host_we        = 1'b0;
        bus.host_addr      = '0;
        bus.host_dump_req  = 1'b0;
        bus.proj_done      = '0;
        bus.proj_we        = '0;
        bus.proj_addr      = '0;
        bus.attn_addr      = '0;
        bus.attn_done      = 1'b0;
    endtask

    // Stimulus only: IDLE -> LOAD -> PROJ.
    task automatic go_proj();
        bus.host_load_req = 1'b1;
        step();
        bus.host_load_req  = 1'b0;
        bus.host_load_done = 1'b1;
        step();
        bus.host_load_done = 1'b0;
    endtask

    // Stimulus only: IDLE -> ... -> first ATTN cycle.
    task automatic go_attn();
        go_proj();
        bus.proj_done = 3'b111;
        step();
        bus.proj_done = 3'b000;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n        = 1'b0;
        bus.host_we  = 1'b1;
        bus.host_addr = 7'd5;
        step();
        step();
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", bus.phase); end
        checks++; if (bus.proj_en !== 1'b0 || bus.attn_start !== 1'b0) begin errors++; $display("FAIL reset_en: got proj_en=%b attn_start=%b want 0/0", bus.proj_en, bus.attn_start); end
        checks++; if (bus.mem_web !== 3'b111 || bus.mem_addr !== 21'd0) begin errors++; $display("FAIL reset_port: got web=%b addr=%h want 111/0", bus.mem_web, bus.mem_addr); end
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_addr !== 7'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_misc: got rd_valid=%b rd_addr=%0d err=%b want 0/0/0", bus.rd_valid, bus.rd_addr, bus.err); end
        clear_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_flow();
        logic [6:0]  a;
        logic [20:0] exp_addr;
        int          starts;
        starts = 0;
        bus.host_load_req = 1'b1;
        step();
        bus.host_load_req = 1'b0;
        checks++; if (bus.phase !== 3'd1) begin errors++; $display("FAIL flow_load: got phase %0d want 1", bus.phase); end
        for (int i = 0; i < 4; i++) begin
            a = 7'(i + 3);
            exp_addr = {a, a, a};
            bus.host_we   = 1'b1;
            bus.host_addr = a;
            #1;
            checks++; if (bus.mem_web !== 3'b000 || bus.mem_addr !== exp_addr) begin errors++; $display("FAIL flow_host_wr%0d: got web=%b addr=%h want 000/%h", i, bus.mem_web, bus.mem_addr, exp_addr); end
            step();
        end
        bus.host_we        = 1'b0;
        bus.host_load_done = 1'b1;
        step();
        bus.host_load_done = 1'b0;
        checks++; if (bus.phase !== 3'd2 || bus.proj_en !== 1'b1) begin errors++; $display("FAIL flow_proj_entry: got phase=%0d proj_en=%b want 2/1", bus.phase, bus.proj_en); end
        for (int k = 0; k <= 14; k++) begin
            bus.proj_done = (k == 10) ? 3'b001 : (k == 12) ? 3'b100 : (k == 14) ? 3'b010 : 3'b000;
            if (k == 5) begin
                bus.proj_we   = 3'b010;
                bus.proj_addr = {7'd0, 7'd9, 7'd0};
                #1;
                checks++; if (bus.mem_web !== 3'b101 || bus.mem_addr !== {7'd0, 7'd9, 7'd0}) begin errors++; $display("FAIL flow_proj_mux: got web=%b addr=%h want 101/%h", bus.mem_web, bus.mem_addr, {7'd0, 7'd9, 7'd0}); end
            end
            if (bus.attn_start === 1'b1) starts++;
            if (k == 13) begin
                checks++; if (bus.phase !== 3'd2) begin errors++; $display("FAIL flow_proj_hold: got phase %0d want 2", bus.phase); end
            end
            step();
            bus.proj_we   = '0;
            bus.proj_addr = '0;
        end
        bus.proj_done = 3'b000;
        checks++; if (bus.phase !== 3'd3 || bus.attn_start !== 1'b1 || bus.proj_en !== 1'b0) begin errors++; $display("FAIL flow_attn_entry: got phase=%0d attn_start=%b proj_en=%b want 3/1/0", bus.phase, bus.attn_start, bus.proj_en); end
        starts++;
        bus.attn_addr = {7'd3, 7'd2, 7'd1};
        #1;
        checks++; if (bus.mem_web !== 3'b111 || bus.mem_addr !== {7'd3, 7'd2, 7'd1}) begin errors++; $display("FAIL flow_attn_mux: got web=%b addr=%h", bus.mem_web, bus.mem_addr); end
        step();
        if (bus.attn_start === 1'b1) starts++;
        bus.attn_done = 1'b1;
        step();
        bus.attn_done = 1'b0;
        if (bus.attn_start === 1'b1) starts++;
        checks++; if (bus.phase !== 3'd4 || starts != 1) begin errors++; $display("FAIL flow_attn_done: got phase=%0d starts=%0d want 4/1", bus.phase, starts); end
        bus.host_dump_req = 1'b1;
        step();
        for (int t = 0; t <= 7; t++) begin
            logic       ev;
            logic [6:0] ea;
            logic [2:0] ep;
            ev = (t >= 2) && (t <= 5);
            ea = ev ? 7'(t - 2) : 7'd0;
            ep = (t <= 4) ? 3'd5 : (t <= 6) ? 3'd6 : 3'd0;
            checks++; if (bus.rd_valid !== ev || bus.rd_addr !== ea || bus.phase !== ep) begin errors++; $display("FAIL flow_dump_t%0d: got v=%b a=%0d ph=%0d want %b/%0d/%0d", t, bus.rd_valid, bus.rd_addr, bus.phase, ev, ea, ep); end
            bus.host_dump_req = (t < 4);
            bus.host_addr     = (t < 4) ? 7'(t) : 7'h55;
            step();
        end
        bus.host_addr = '0;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL flow_err: got %b want 0", bus.err); end
    endtask

    task automatic test_simultaneous_done();
        go_proj();
        bus.proj_done = 3'b111;
        checks++; if (bus.proj_en !== 1'b1) begin errors++; $display("FAIL simul_proj_en_hi: got %b want 1", bus.proj_en); end
        step();
        bus.proj_done = 3'b000;
        checks++; if (bus.phase !== 3'd3 || bus.proj_en !== 1'b0 || bus.attn_start !== 1'b1) begin errors++; $display("FAIL simul_attn: got phase=%0d proj_en=%b attn_start=%b want 3/0/1", bus.phase, bus.proj_en, bus.attn_start); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL simul_abort: got phase %0d want 0", bus.phase); end
    endtask

    task automatic test_abort_dump();
        go_attn();
        bus.attn_done = 1'b1;
        step();
        bus.attn_done     = 1'b0;
        bus.host_dump_req = 1'b1;
        step();
        bus.host_addr = 7'd20;
        step();
        bus.host_addr = 7'd21;
        step();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 7'd20) begin errors++; $display("FAIL abort_pre: got v=%b a=%0d want 1/20", bus.rd_valid, bus.rd_addr); end
        bus.abort     = 1'b1;
        bus.host_addr = 7'd22;
        step();
        bus.abort         = 1'b0;
        bus.host_dump_req = 1'b0;
        bus.host_addr     = 7'd0;
        checks++; if (bus.rd_valid !== 1'b0 || bus.phase !== 3'd0 || bus.proj_en !== 1'b0) begin errors++; $display("FAIL abort_next: got v=%b ph=%0d proj_en=%b want 0/0/0", bus.rd_valid, bus.phase, bus.proj_en); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet%0d: got rd_valid %b want 0", i, bus.rd_valid); end
        end
    endtask

    task automatic test_protocol_err();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL perr_pre: got err %b want 0", bus.err); end
        go_proj();
        bus.host_we   = 1'b1;
        bus.host_addr = 7'd33;
        bus.proj_we   = 3'b010;
        bus.proj_addr = {7'd0, 7'd9, 7'd0};
        #1;
        checks++; if (bus.mem_web !== 3'b101 || bus.mem_addr !== {7'd0, 7'd9, 7'd0}) begin errors++; $display("FAIL perr_mux: got web=%b addr=%h want 101/%h", bus.mem_web, bus.mem_addr, {7'd0, 7'd9, 7'd0}); end
        step();
        bus.host_we   = 1'b0;
        bus.proj_we   = '0;
        bus.proj_addr = '0;
        checks++; if (bus.err !== 1'b1 || bus.phase !== 3'd2) begin errors++; $display("FAIL perr_set: got err=%b ph=%0d want 1/2", bus.err, bus.phase); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.err !== 1'b1 || bus.phase !== 3'd0 || bus.proj_en !== 1'b0) begin errors++; $display("FAIL perr_sticky: got err=%b ph=%0d proj_en=%b want 1/0/0", bus.err, bus.phase, bus.proj_en); end
    endtask

    task automatic test_reset_mid_proj();
        go_proj();
        bus.proj_we = 3'b111;
        #1;
        checks++; if (bus.proj_en !== 1'b1 || bus.mem_web !== 3'b000) begin errors++; $display("FAIL rstp_pre: got proj_en=%b web=%b want 1/000", bus.proj_en, bus.mem_web); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.proj_en !== 1'b0 || bus.mem_web !== 3'b111 || bus.phase !== 3'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL rstp_async: got proj_en=%b web=%b ph=%0d err=%b want 0/111/0/0", bus.proj_en, bus.mem_web, bus.phase, bus.err); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_watchdog();
        go_attn();
`ifdef QKV_SEQ_WDOG_EN
        for (int t = 1; t <= 64; t++) begin
            step();
            if (t == 63) begin
                checks++; if (bus.phase !== 3'd3 || bus.err !== 1'b0) begin errors++; $display("FAIL wdog_63: got ph=%0d err=%b want 3/0", bus.phase, bus.err); end
            end
        end
        checks++; if (bus.phase !== 3'd0 || bus.err !== 1'b1) begin errors++; $display("FAIL wdog_64: got ph=%0d err=%b want 0/1", bus.phase, bus.err); end
`else
        repeat (200) step();
        checks++; if (bus.phase !== 3'd3 || bus.err !== 1'b0) begin errors++; $display("FAIL wdog_off: got ph=%0d err=%b want 3/0", bus.phase, bus.err); end
`endif
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL wdog_exit: got ph=%0d want 0", bus.phase); end
    endtask

    initial begin
        test_reset();
        test_full_flow();
        test_simultaneous_done();
        test_abort_dump();
        test_protocol_err();
        test_reset_mid_proj();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
